// File: rtl/store_sequencer.sv
// Sequences SB/SH/SW stores onto a single shared DMEM write port: lane alignment,
// byte-mask generation, and splitting of word-crossing stores into two aligned writes.
module store_sequencer #(
    parameter int ADDR_W           = 14,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    input  logic [2:0]        req_funct3,
    input  logic              dmem_gnt,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_din,
    output logic              st_done,
    output logic              st_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, RESP} state_t;

    state_t      state_q;
    logic        split_q;
    logic [31:0] data_q;
    logic [1:0]  off_q;
    logic [2:0]  size_q;

    logic [1:0]  off_d;
    logic [2:0]  size_d;
    logic        illegal_d;
    logic        split_d;
    logic        accept;

    // Byte-address bits above the DMEM word range are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic [3:0] lo_mask(input logic [1:0] o, input logic [2:0] n);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (i >= int'(o)) && (i < int'(o) + int'(n));
        end
        return m;
    endfunction

    function automatic logic [3:0] hi_mask(input logic [1:0] o, input logic [2:0] n);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (i < int'(o) + int'(n) - 4);
        end
        return m;
    endfunction

    function automatic logic [31:0] lo_lanes(input logic [31:0] d, input logic [1:0] o);
        return d << {o, 3'b000};
    endfunction

    function automatic logic [31:0] hi_lanes(input logic [31:0] d, input logic [1:0] o);
        return d >> (6'd32 - {1'b0, o, 3'b000});
    endfunction

    always_comb begin
        off_d     = req_addr[1:0];
        size_d    = 3'd1;
        illegal_d = 1'b0;
        case (req_funct3)
            3'b000:  size_d = 3'd1;
            3'b001:  size_d = 3'd2;
            3'b010:  size_d = 3'd4;
            default: illegal_d = 1'b1;
        endcase
        split_d = ({1'b0, off_d} + size_d) > 3'd4;
        accept  = req_valid && req_ready && (state_q == IDLE);
    end

    // Request payload is only meaningful after an accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= req_data;
            off_q  <= off_d;
            size_q <= size_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            split_q   <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            dmem_we   <= '0;
            dmem_addr <= '0;
            dmem_din  <= '0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    st_done <= 1'b0;
                    st_err  <= 1'b0;
                    if (accept) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        split_q   <= split_d;
                        if (illegal_d || (split_d && !SPLIT_MISALIGNED)) begin
                            state_q <= RESP;
                            st_err  <= 1'b1;
                        end else begin
                            state_q   <= WR_LO;
                            dmem_we   <= lo_mask(off_d, size_d);
                            dmem_addr <= req_addr[ADDR_W+1:2];
                            dmem_din  <= lo_lanes(req_data, off_d);
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WR_LO: begin
                    if (dmem_gnt) begin
                        if (split_q) begin
                            state_q   <= WR_HI;
                            dmem_we   <= hi_mask(off_q, size_q);
                            dmem_addr <= dmem_addr + ADDR_W'(1);
                            dmem_din  <= hi_lanes(data_q, off_q);
                        end else begin
                            state_q <= RESP;
                            dmem_we <= '0;
                            st_done <= 1'b1;
                        end
                    end
                end
                WR_HI: begin
                    if (dmem_gnt) begin
                        state_q <= RESP;
                        dmem_we <= '0;
                        st_done <= 1'b1;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    st_done   <= 1'b0;
                    st_err    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_sequencer.sv
// Table-driven scoreboard bench for store_sequencer, plus stall, reset and no-split sequences.
module tb_store_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_funct3;
    logic        dmem_gnt;
    logic [3:0]  dmem_we;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic        st_done, st_err, busy;

    logic        rv0, rdy0, g0, dn0, er0, bz0;
    logic [31:0] ra0, rd0, din0;
    logic [2:0]  rf0;
    logic [3:0]  we0;
    logic [13:0] ad0;

    store_sequencer #(.ADDR_W(14), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
        .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .st_done(st_done), .st_err(st_err), .busy(busy)
    );

    store_sequencer #(.ADDR_W(14), .SPLIT_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_ready(rdy0),
        .req_addr(ra0), .req_data(rd0), .req_funct3(rf0),
        .dmem_gnt(g0), .dmem_we(we0), .dmem_addr(ad0),
        .dmem_din(din0), .st_done(dn0), .st_err(er0), .busy(bz0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
        logic        err;
        logic        split;
        logic [3:0]  we_lo;
        logic [13:0] a_lo;
        logic [31:0] din_lo;
        logic [3:0]  we_hi;
        logic [13:0] a_hi;
        logic [31:0] din_hi;
    } vec_t;

    typedef struct {
        logic [3:0]  we;
        logic [13:0] a;
        logic [31:0] din;
    } wr_t;

    typedef struct {
        logic err;
        int   acc;
        int   lat;
    } rsp_t;

    vec_t vecs[12];
    wr_t  wq[$];
    rsp_t rq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] lanes(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurred/timed out, expected otherwise (cycle %0d)", name, cyc);
    endtask

    task automatic wait_ready(input bit which);
        int c;
        c = 0;
        @(negedge clk);
        while (((which ? rdy0 : req_ready) !== 1'b1) && c < 50) begin
            @(negedge clk);
            c++;
        end
        if ((which ? rdy0 : req_ready) !== 1'b1) fail_evt("req_ready_timeout");
    endtask

    task automatic issue(input vec_t v, input bit full, input int lat);
        wr_t  w;
        rsp_t r;
        wait_ready(1'b0);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_data   = v.data;
        req_funct3 = v.f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!v.err) begin
            w = '{v.we_lo, v.a_lo, v.din_lo};
            wq.push_back(w);
            if (v.split && full) begin
                w = '{v.we_hi, v.a_hi, v.din_hi};
                wq.push_back(w);
            end
        end
        if (full) begin
            r = '{v.err, cyc, lat};
            rq.push_back(r);
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (rq.size() != 0 && c < 40) begin
            @(posedge clk);
            c++;
        end
        if (rq.size() != 0) begin
            fail_evt("response_timeout");
            rq.delete();
            wq.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        wr_t  e;
        rsp_t r;

        vecs[0]  = '{32'h103,   32'h000000AB, 3'b000, 1'b0, 1'b0, 4'b1000, 14'h040, 32'hAB000000, 4'b0000, 14'h000, 32'h0};
        vecs[1]  = '{32'h202,   32'h11223344, 3'b010, 1'b0, 1'b1, 4'b1100, 14'h080, 32'h33440000, 4'b0011, 14'h081, 32'h00001122};
        vecs[2]  = '{32'h100,   32'hDEADBEEF, 3'b010, 1'b0, 1'b0, 4'b1111, 14'h040, 32'hDEADBEEF, 4'b0000, 14'h000, 32'h0};
        vecs[3]  = '{32'h102,   32'h0000CAFE, 3'b001, 1'b0, 1'b0, 4'b1100, 14'h040, 32'hCAFE0000, 4'b0000, 14'h000, 32'h0};
        vecs[4]  = '{32'h101,   32'h00001234, 3'b001, 1'b0, 1'b0, 4'b0110, 14'h040, 32'h00123400, 4'b0000, 14'h000, 32'h0};
        vecs[5]  = '{32'h007,   32'h0000BEEF, 3'b001, 1'b0, 1'b1, 4'b1000, 14'h001, 32'hEF000000, 4'b0001, 14'h002, 32'h000000BE};
        vecs[6]  = '{32'h000,   32'h00000055, 3'b000, 1'b0, 1'b0, 4'b0001, 14'h000, 32'h00000055, 4'b0000, 14'h000, 32'h0};
        vecs[7]  = '{32'hFFFD,  32'hA1B2C3D4, 3'b010, 1'b0, 1'b1, 4'b1110, 14'h3FFF, 32'hB2C3D400, 4'b0001, 14'h000, 32'h000000A1};
        vecs[8]  = '{32'h040,   32'h12345678, 3'b011, 1'b1, 1'b0, 4'b0000, 14'h000, 32'h0,         4'b0000, 14'h000, 32'h0};
        vecs[9]  = '{32'h043,   32'h12345678, 3'b111, 1'b1, 1'b0, 4'b0000, 14'h000, 32'h0,         4'b0000, 14'h000, 32'h0};
        vecs[10] = '{32'h003,   32'h01020304, 3'b010, 1'b0, 1'b1, 4'b1000, 14'h000, 32'h04000000, 4'b0111, 14'h001, 32'h00010203};
        vecs[11] = '{32'h12345, 32'h00000066, 3'b000, 1'b0, 1'b0, 4'b0010, 14'h08D1, 32'h00006600, 4'b0000, 14'h000, 32'h0};

        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_funct3 = '0; dmem_gnt = 1'b1;
        rv0 = 1'b0; ra0 = '0; rd0 = '0; rf0 = '0; g0 = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (dmem_gnt && dmem_we != 4'b0000) begin
                        if (wq.size() == 0) fail_evt("unexpected_write");
                        else begin
                            e = wq.pop_front();
                            chk("write_we", 32'(dmem_we), 32'(e.we));
                            chk("write_addr", 32'(dmem_addr), 32'(e.a));
                            chk("write_din", dmem_din & lanes(dmem_we), e.din & lanes(e.we));
                        end
                    end
                    if (st_done || st_err) begin
                        if (rq.size() == 0) fail_evt("unexpected_response");
                        else begin
                            r = rq.pop_front();
                            chk("resp_err", 32'(st_err), 32'(r.err));
                            chk("resp_done", 32'(st_done), 32'(!r.err));
                            if (r.lat >= 0) chk("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
                        end
                    end
                end
            end
        join_none

        // Reset state, then one more cycle before req_ready rises.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
        chk("rst_done_err", 32'({st_done, st_err}), 32'd0);
        chk("rst_ready0", 32'(rdy0), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_reset_cycle", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            lat = vecs[i].err ? 0 : (vecs[i].split ? 2 : 1);
            issue(vecs[i], 1'b1, lat);
            wait_idle();
        end

        // Grant withheld for five cycles on a split SH.
        dmem_gnt = 1'b0;
        issue(vecs[5], 1'b1, -1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_we", 32'(dmem_we), 32'b1000);
            chk("stall_addr", 32'(dmem_addr), 32'h1);
            chk("stall_din", dmem_din & 32'hFF000000, 32'hEF000000);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_done", 32'(st_done), 32'd0);
        end
        @(posedge clk);
        #1 dmem_gnt = 1'b1;
        wait_idle();

        // Reset while the high half is pending: it must never be written.
        issue(vecs[1], 1'b0, -1);
        @(posedge clk);
        #1 dmem_gnt = 1'b0;
        @(negedge clk);
        chk("hi_pending_we", 32'(dmem_we), 32'b0011);
        chk("hi_pending_addr", 32'(dmem_addr), 32'h81);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_we", 32'(dmem_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(st_done), 32'd0);
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(vecs[4], 1'b1, 1);
        wait_idle();

        // Split disabled: misaligned SW is dropped with st_err, aligned SW still writes.
        wait_ready(1'b1);
        rv0 = 1'b1; ra0 = 32'h1; rd0 = 32'h11223344; rf0 = 3'b010;
        @(posedge clk);
        #1 rv0 = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("nosplit_we", 32'(we0), 32'd0);
            chk("nosplit_err", 32'(er0), 32'(j == 0));
            chk("nosplit_done", 32'(dn0), 32'd0);
        end
        wait_ready(1'b1);
        rv0 = 1'b1; ra0 = 32'h4; rd0 = 32'h600DF00D; rf0 = 3'b010;
        @(posedge clk);
        #1 rv0 = 1'b0;
        @(negedge clk);
        chk("nosplit_aligned_we", 32'(we0), 32'b1111);
        chk("nosplit_aligned_addr", 32'(ad0), 32'h1);
        chk("nosplit_aligned_din", din0, 32'h600DF00D);
        @(negedge clk);
        chk("nosplit_aligned_done", 32'({dn0, er0}), 32'b10);

        repeat (4) @(posedge clk);
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("resps_outstanding", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
